// File: rtl/neander_x_muldiv_seq.sv
// Sequential multiply/divide engine for the NEANDER-X datapath.
// Shift-add multiply and restoring divide, one bit per clock cycle.
module neander_x_muldiv_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_high,
    output logic              carry_out
);

    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod_nx;
    logic [DATA_W:0]     trial;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   rem_nx;
    logic [DATA_W-1:0]   quo_nx;

    // Multiplier sits in the low half and is consumed as the product grows.
    always_comb begin
        sum     = {1'b0, prod[2*DATA_W-1:DATA_W]}
                + ({1'b0, a_q} & {(DATA_W+1){prod[0]}});
        prod_nx = {sum, prod[DATA_W-1:1]};
    end

    // Working remainder is DATA_W+1 bits; a set MSB of diff means a borrow.
    always_comb begin
        trial  = {rem, quo[DATA_W-1]};
        diff   = trial - {1'b0, b_q};
        rem_nx = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_nx = {quo[DATA_W-2:0], ~diff[DATA_W]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_high <= '0;
            carry_out   <= 1'b0;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= CW'(DATA_W);
                        prod <= {{DATA_W{1'b0}}, b};
                        rem  <= '0;
                        quo  <= a;
                        if (op == OP_RSV) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result      <= '0;
                            result_high <= '0;
                            carry_out   <= 1'b0;
                        end else if (op == OP_DIV && b == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result      <= '1;
                            result_high <= a;
                            carry_out   <= 1'b1;
                        end else if (op == OP_MOD && b == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result      <= a;
                            result_high <= '1;
                            carry_out   <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    prod <= prod_nx;
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        case (op_q)
                            OP_MUL: begin
                                result      <= prod_nx[DATA_W-1:0];
                                result_high <= prod_nx[2*DATA_W-1:DATA_W];
                                carry_out   <= |prod_nx[2*DATA_W-1:DATA_W];
                            end
                            OP_MOD: begin
                                result      <= rem_nx;
                                result_high <= quo_nx;
                                carry_out   <= 1'b0;
                            end
                            default: begin
                                result      <= quo_nx;
                                result_high <= rem_nx;
                                carry_out   <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neander_x_muldiv_seq.sv
// Directed bench for the sequential multiply/divide engine.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_neander_x_muldiv_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_high;
    logic       carry_out;

    int tests = 0;
    int fails = 0;
    int lat;
    int saw_done;

    always #5 clk = ~clk;

    neander_x_muldiv_seq #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_high(result_high),
        .carry_out  (carry_out)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle N+1.
    task automatic start_op(input logic [1:0] o, input logic [7:0] x,
                            input logic [7:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; op = ~o;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [7:0] x, input logic [7:0] y,
                          input int el, input int er, input int eh,
                          input int ec);
        int l;
        start_op(o, x, y);
        if (el > 1) chk({tag, "_busy"}, busy, 1);
        wait_done(l);
        chk({tag, "_lat"}, l, el);
        chk({tag, "_res"}, result, er);
        chk({tag, "_hi"}, result_high, eh);
        chk({tag, "_c"}, carry_out, ec);
        chk({tag, "_busy_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, result, er);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", result, 0);
        chk("rst_hi", result_high, 0);
        chk("rst_c", carry_out, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul13x11", 2'b00, 8'd13, 8'd11, 9, 8'h8F, 8'h00, 0);
        run_op("mul200", 2'b00, 8'd200, 8'd200, 9, 8'h40, 8'h9C, 1);
        run_op("mulff", 2'b00, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1);
        run_op("mul0", 2'b00, 8'h00, 8'h37, 9, 8'h00, 8'h00, 0);
        run_op("div200", 2'b01, 8'd200, 8'd7, 9, 8'h1C, 8'h04, 0);
        run_op("mod200", 2'b10, 8'd200, 8'd7, 9, 8'h04, 8'h1C, 0);
        run_op("div7", 2'b01, 8'd7, 8'd200, 9, 8'h00, 8'h07, 0);
        run_op("divff1", 2'b01, 8'hFF, 8'h01, 9, 8'hFF, 8'h00, 0);
        run_op("divz", 2'b01, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 1);
        run_op("modz", 2'b10, 8'h55, 8'h00, 1, 8'h55, 8'hFF, 1);
        run_op("rsv", 2'b11, 8'h12, 8'h34, 1, 8'h00, 8'h00, 0);

        // start held high throughout; new request lands in the DONE cycle
        @(negedge clk);
        op = 2'b01; a = 8'd200; b = 8'd7; start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k < 9) begin
                op = 2'b00; a = 8'd13; b = 8'd11;
            end else if (k > 9) begin
                start = 1'b0;
                a = 8'(k * 37); b = 8'(k * 11); op = 2'b01;
            end
            if (k == 4) chk("b2b_busy", busy, 1);
            if (k == 5) chk("b2b_nodone", done, 0);
            if (k == 9) begin
                chk("b2b_done1", done, 1);
                chk("b2b_res1", result, 8'h1C);
                chk("b2b_hi1", result_high, 8'h04);
            end
            if (k == 13) begin
                chk("b2b_busy2", busy, 1);
                chk("b2b_hold", result, 8'h1C);
            end
            if (k == 17) chk("b2b_nodone2", done, 0);
            if (k == 18) begin
                chk("b2b_done2", done, 1);
                chk("b2b_res2", result, 8'h8F);
                chk("b2b_hi2", result_high, 8'h00);
            end
        end
        start = 1'b0;
        @(negedge clk);

        // reset in the middle of a multiply
        run_op("pre_rst", 2'b00, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1);
        start_op(2'b00, 8'd200, 8'd200);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res", result, 0);
        chk("mid_rst_hi", result_high, 0);
        chk("mid_rst_c", carry_out, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        chk("mid_rst_nodone", saw_done, 0);
        run_op("post_rst", 2'b00, 8'd200, 8'd200, 9, 8'h40, 8'h9C, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
